// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: self-clears to NOP after reset, fills from a ready/valid stream,
// then serves a registered one-cycle fetch honouring stall and flush.
module instr_mem_loadable #(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        DEPTH     = 64,
  parameter bit                 BYTE_ADDR = 1'b1,
  parameter logic [DATA_W-1:0]  NOP_WORD  = 32'hFC00_0000,
  parameter int unsigned        IDX_W     = $clog2(DEPTH),
  parameter int unsigned        CNT_W     = IDX_W + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_req_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic [CNT_W-1:0]  ld_count_o,
  output logic              run_o,
  input  logic              fetch_en_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_valid_o,
  output logic              addr_err_o
);

  typedef enum logic [1:0] {StClear, StLoad, StRun} state_e;

  localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DepthPc  = ADDR_W'(DEPTH);

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic              err_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              ld_hs;
  logic [ADDR_W-1:0] fidx;
  logic              misaligned;
  logic              out_of_range;
  logic              fetch_bad;
  logic [DATA_W-1:0] rd_word;

  assign ld_ready_o    = (state_q == StLoad);
  assign run_o         = (state_q == StRun);
  assign ld_count_o    = cnt_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign addr_err_o    = err_q;

  assign ld_hs = ld_valid_i && ld_ready_o;

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = NOP_WORD;
    if (state_q == StClear) begin
      mem_we = 1'b1;
    end else if (ld_hs) begin
      mem_we    = 1'b1;
      mem_wdata = ld_data_i;
    end
  end

  // Index is compared at full pc width so high address bits never alias into the array.
  always_comb begin
    fidx       = pc_i;
    misaligned = 1'b0;
    if (BYTE_ADDR) begin
      fidx       = pc_i >> 2;
      misaligned = (pc_i[1:0] != 2'b00);
    end
  end

  assign out_of_range = (fidx >= DepthPc);
  assign fetch_bad    = out_of_range || misaligned;
  assign rd_word      = mem_q[fidx[IDX_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[ptr_q] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StClear;
      ptr_q   <= '0;
      cnt_q   <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (ptr_q == LastIdx) begin
            state_q <= StLoad;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + IDX_W'(1);
          end
        end
        StLoad: begin
          if (ld_hs) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (ld_last_i || (ptr_q == LastIdx)) begin
              state_q <= StRun;
              ptr_q   <= '0;
            end else begin
              ptr_q <= ptr_q + IDX_W'(1);
            end
          end
        end
        StRun: begin
          if (load_req_i) begin
            state_q <= StLoad;
            ptr_q   <= '0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= StClear;
          ptr_q   <= '0;
        end
      endcase

      if (flush_i) begin
        instr_q <= NOP_WORD;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else if (stall_i) begin
        instr_q <= instr_q;
      end else if ((state_q != StRun) || load_req_i) begin
        instr_q <= NOP_WORD;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else if (fetch_en_i) begin
        valid_q <= 1'b1;
        if (fetch_bad) begin
          instr_q <= NOP_WORD;
          err_q   <= 1'b1;
        end else begin
          instr_q <= rd_word;
          err_q   <= 1'b0;
        end
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, loadable instruction memory for the segmented (pipelined) processor. Replaces the fixed combinational instruction ROM with a synchronous array that clears itself to NOP after reset and is filled through a ready/valid load stream. After loading, it serves the fetch stage with a registered one-cycle read that honours pipeline stall and flush. Out-of-range and misaligned fetches return a NOP and raise an error flag.

## Interface
- `DATA_W`, 32, instruction width.
- `ADDR_W`, 32, width of the `pc` fetch address.
- `DEPTH`, 64, number of instruction words; any value ≥ 2 (need not be a power of 2).
- `BYTE_ADDR`, 1, 1: `pc` is a byte address, word index = `pc >> 2`, `pc[1:0]` must be 0; 0: `pc` is a word index.
- `NOP_WORD`, 32'hFC00_0000, fill and bubble value (the processor's NOP encoding).
- `IDX_W`, derived, = clog2(DEPTH); `CNT_W` = IDX_W+1.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-high.
- `load_req` in 1: one-cycle pulse in RUN that starts a reload from index 0.
- `ld_valid` in 1: load word present.
- `ld_ready` out 1: high exactly when state = LOAD (combinational from state).
- `ld_data` in DATA_W: load word.
- `ld_last` in 1: marks the final word of the program.
- `ld_count` out CNT_W: words accepted since the last entry into LOAD.
- `run` out 1: high when state = RUN.
- `fetch_en` in 1: fetch request for `pc`.
- `stall` in 1: hold the fetch output.
- `flush` in 1: kill the fetch output.
- `pc` in ADDR_W: fetch address.
- `instr` out DATA_W: fetched instruction (registered).
- `instr_valid` out 1: `instr` holds a real fetch.
- `addr_err` out 1: last fetch was out of range or misaligned.

## Operation
- FSM states: CLEAR, LOAD, RUN.
- Reset forces CLEAR with `ptr` = 0, `ld_count` = 0, `instr` = NOP_WORD, `instr_valid` = 0, `addr_err` = 0. Hence `ld_ready` = 0 and `run` = 0.
- CLEAR: each cycle writes `mem[ptr]` = NOP_WORD and increments `ptr`. The cycle that writes index DEPTH-1 moves to LOAD with `ptr` = 0. All load inputs are ignored.
- LOAD: a handshake (`ld_valid` & `ld_ready`) writes `mem[ptr]` = `ld_data` and increments both `ptr` and `ld_count`. If `ld_last` = 1 or `ptr` = DEPTH-1 on that handshake, go to RUN. Unwritten entries keep their previous content. `load_req` is ignored.
- RUN: `ld_ready` = 0. A `load_req` pulse moves to LOAD with `ptr` = 0 and `ld_count` = 0. There is no re-clear, so stale words above the new program remain.
- Fetch index: if BYTE_ADDR, index = `pc[ADDR_W-1:2]`, misaligned if `pc[1:0]` ≠ 0. Otherwise index = `pc`. Out of range if index ≥ DEPTH, compared at full width with no truncation or wrap.
- Fetch register update, in priority order:
  1. reset.
  2. `flush`: `instr` = NOP_WORD, `instr_valid` = 0, `addr_err` = 0.
  3. `stall`: hold all three outputs.
  4. state ≠ RUN or `load_req`: `instr` = NOP_WORD, `instr_valid` = 0, `addr_err` = 0.
  5. `fetch_en`: if the fetch is out of range or misaligned, `instr` = NOP_WORD, `instr_valid` = 1, `addr_err` = 1. Otherwise `instr` = `mem[index]`, `instr_valid` = 1, `addr_err` = 0.
  6. No `fetch_en`: `instr_valid` = 0; `instr` and `addr_err` hold.
- Reset mid-LOAD or mid-RUN: the whole array is re-cleared and the FSM restarts at CLEAR.

## Timing
- CLEAR lasts exactly DEPTH cycles after the first cycle with `reset` low. `ld_ready` rises in cycle DEPTH+1 after reset release.
- Load: one word per cycle at full throughput. `run` rises the cycle after the handshake that carries `ld_last`.
- Fetch latency: 1 cycle. `pc` sampled at edge N appears on `instr` after edge N.
- The first valid fetch is possible the cycle `run` = 1. The word written on the final load handshake is readable in that same cycle.
- `load_req` takes effect at the next edge. `ld_ready` is high the following cycle.

## Test plan
- DEPTH=16, BYTE_ADDR=1: assert reset 2 cycles, then release. Check `ld_ready` = 0 for 16 cycles, then 1. Check `instr` = 32'hFC00_0000 and `instr_valid` = 0 throughout.
- Load 9 words 0xAC23_0000, 0x8C3F_0000, … with `ld_last` on the 9th. Then `run` = 1 and `ld_count` = 9. Fetch `pc` = 0, 4, 32 → `instr` = 0xAC23_0000, 0x8C3F_0000, word 8 on consecutive cycles. `pc` = 36 → NOP_WORD, `addr_err` = 0 (index 9 is unwritten and in range).
- Fetch `pc` = 64 → NOP_WORD, `instr_valid` = 1, `addr_err` = 1. Fetch `pc` = 6 → same result (misaligned).
- Fetch `pc` = 4 then raise `stall` 3 cycles → `instr` holds 0x8C3F_0000. Assert `flush` and `stall` together → `instr` = NOP_WORD, `instr_valid` = 0.
- Load with `ld_valid` gaps, 16 words, no `ld_last` → RUN after the 16th handshake, `ld_count` = 16. A 17th `ld_valid` is not accepted.
- Assert `load_req` in RUN, load 2 words (0x1, 0x2, `ld_last`) → `pc` = 8 still returns the old word 2. Then reset mid-LOAD → 16-cycle CLEAR, and every index reads NOP_WORD afterwards.
